// File: rtl/tdc_meas_sequencer.sv
// tdc_meas_sequencer: drives tdc_top launch/capture/val_in and accumulates 2**NS_LOG2 hw samples.
// Define TDC_SEQ_MINMAX_EN to track hw_min/hw_max; otherwise both outputs tie to 0.
module tdc_meas_sequencer #(
  parameter int N_O     = 6,
  parameter int NS_LOG2 = 4,
  parameter int TO_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 start_i,
  input  logic [7:0]           cfg_delay_i,
  output logic                 clk_launch_o,
  output logic                 clk_capture_o,
  output logic                 val_in_o,
  input  logic [N_O:0]         hw_i,
  input  logic                 val_out_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_timeout_o,
  output logic [N_O+NS_LOG2:0] sum_o,
  output logic [N_O:0]         hw_min_o,
  output logic [N_O:0]         hw_max_o
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, COLLECT, RELEASE, RECOVER, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] dly_q, dly_d;
  logic [TO_W-1:0] to_q, to_d, to_nx;
  logic [NS_LOG2-1:0] cnt_q, cnt_d;
  logic launch_q, launch_d, cap_q, cap_d, val_q, val_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, awaiting;
  logic [N_O+NS_LOG2:0] sum_q, sum_d;
`ifdef TDC_SEQ_MINMAX_EN
  logic [N_O:0] min_q, min_d, max_q, max_d;
`endif
  assign to_nx = to_q + TO_W'(1);
  // COLLECT waits for val_out high, RECOVER for val_out low; both share the timeout
  assign awaiting = (state_q == COLLECT) ? !val_out_i : (state_q == RECOVER) && val_out_i;
  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    to_d     = to_q;
    cnt_d    = cnt_q;
    launch_d = launch_q;
    cap_d    = cap_q;
    val_d    = val_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    sum_d    = sum_q;
`ifdef TDC_SEQ_MINMAX_EN
    min_d    = min_q;
    max_d    = max_q;
`endif
    case (state_q)
      IDLE: if (en_i && start_i) begin
        state_d  = LAUNCH;
        launch_d = 1'b1;
        val_d    = 1'b1;
        busy_d   = 1'b1;
        sum_d    = '0;
        err_d    = 1'b0;
        cnt_d    = '0;
`ifdef TDC_SEQ_MINMAX_EN
        min_d    = '1;
        max_d    = '0;
`endif
      end
      LAUNCH: begin
        dly_d   = cfg_delay_i - 8'd1;
        state_d = (cfg_delay_i == 8'd0) ? CAPTURE : WAIT;
        cap_d   = (cfg_delay_i == 8'd0);
      end
      WAIT: begin
        dly_d   = dly_q - 8'd1;
        state_d = (dly_q == 8'd0) ? CAPTURE : WAIT;
        cap_d   = (dly_q == 8'd0);
      end
      CAPTURE: begin
        to_d    = '0;
        state_d = COLLECT;
      end
      COLLECT: if (val_out_i) begin
        sum_d    = sum_q + {{NS_LOG2{1'b0}}, hw_i};
`ifdef TDC_SEQ_MINMAX_EN
        min_d    = (hw_i < min_q) ? hw_i : min_q;
        max_d    = (hw_i > max_q) ? hw_i : max_q;
`endif
        launch_d = 1'b0;
        cap_d    = 1'b0;
        val_d    = 1'b0;
        state_d  = RELEASE;
      end
      RELEASE: begin
        cnt_d   = cnt_q + NS_LOG2'(1);
        to_d    = '0;
        state_d = RECOVER;
      end
      RECOVER: if (!val_out_i) begin
        state_d  = (cnt_q == '0) ? DONE : LAUNCH;
        done_d   = (cnt_q == '0);
        launch_d = (cnt_q != '0);
        val_d    = (cnt_q != '0);
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (awaiting && &to_nx) begin
      state_d  = DONE;
      done_d   = 1'b1;
      err_d    = 1'b1;
      launch_d = 1'b0;
      cap_d    = 1'b0;
      val_d    = 1'b0;
    end else if (awaiting) begin
      to_d = to_nx;
    end
    if (state_q != IDLE && !en_i) begin
      state_d  = IDLE;
      launch_d = 1'b0;
      cap_d    = 1'b0;
      val_d    = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dly_q    <= '0;
      to_q     <= '0;
      cnt_q    <= '0;
      launch_q <= 1'b0;
      cap_q    <= 1'b0;
      val_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      sum_q    <= '0;
`ifdef TDC_SEQ_MINMAX_EN
      min_q    <= '1;
      max_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      to_q     <= to_d;
      cnt_q    <= cnt_d;
      launch_q <= launch_d;
      cap_q    <= cap_d;
      val_q    <= val_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sum_q    <= sum_d;
`ifdef TDC_SEQ_MINMAX_EN
      min_q    <= min_d;
      max_q    <= max_d;
`endif
    end
  end
  assign clk_launch_o  = launch_q;
  assign clk_capture_o = cap_q;
  assign val_in_o      = val_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_timeout_o = err_q;
  assign sum_o         = sum_q;
`ifdef TDC_SEQ_MINMAX_EN
  assign hw_min_o = min_q;
  assign hw_max_o = max_q;
`else
  assign hw_min_o = '0;
  assign hw_max_o = '0;
`endif
endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// tb_tdc_meas_sequencer: directed bench with a TDC responder model for tdc_meas_sequencer.
module tb_tdc_meas_sequencer;
  logic clk = 1'b0, rst = 1'b1, en_i = 1'b0, start_i = 1'b0, val_out_i = 1'b0;
  logic [7:0] cfg_delay_i = 8'd0;
  logic [6:0] hw_i = 7'd0, hw_min_o, hw_max_o;
  logic clk_launch_o, clk_capture_o, val_in_o, busy_o, done_o, err_timeout_o;
  logic [10:0] sum_o;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, t_l = 0, t_c = 0, t_d = 0, done_cnt = 0, n_launch = 0;
  logic l_prev = 1'b0, c_prev = 1'b0;
  int k = 0, smp = 0, stuck_n = 0;
  bit resp_on = 1'b1;
  logic [6:0] hw_tab [16];
`ifdef TDC_SEQ_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  tdc_meas_sequencer dut (
    .clk(clk), .rst(rst), .en_i(en_i), .start_i(start_i), .cfg_delay_i(cfg_delay_i),
    .clk_launch_o(clk_launch_o), .clk_capture_o(clk_capture_o), .val_in_o(val_in_o),
    .hw_i(hw_i), .val_out_i(val_out_i), .busy_o(busy_o), .done_o(done_o),
    .err_timeout_o(err_timeout_o), .sum_o(sum_o), .hw_min_o(hw_min_o), .hw_max_o(hw_max_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // edge monitor, sampled 1 time unit after each rising clock edge
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (clk_launch_o && !l_prev) begin t_l = cyc; n_launch++; end
    if (clk_capture_o && !c_prev) t_c = cyc;
    if (done_o) begin done_cnt++; t_d = cyc; end
    l_prev = clk_launch_o;
    c_prev = clk_capture_o;
  end

  // TDC model: val_out rises 2 cycles after capture, falls once capture drops
  initial forever begin
    @(negedge clk);
    if (clk_capture_o) begin
      k++;
      if (k == 2 && resp_on) begin
        val_out_i = 1'b1;
        hw_i = hw_tab[smp];
        smp++;
      end
    end else begin
      k = 0;
      if (stuck_n == 0 || smp < stuck_n) val_out_i = 1'b0;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [7:0] d);
    @(negedge clk);
    smp = 0;
    cfg_delay_i = d;
    en_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done_o && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!done_o) check("done_wait", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_launch", clk_launch_o, 0);
    check("rst_capture", clk_capture_o, 0);
    check("rst_val_in", val_in_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_timeout_o, 0);
    check("rst_sum", sum_o, 0);
    check("rst_min", hw_min_o, MM ? 127 : 0);
    check("rst_max", hw_max_o, 0);
    rst = 1'b0;

    // constant 20, cfg_delay 3
    for (int i = 0; i < 16; i++) hw_tab[i] = 7'd20;
    done_cnt = 0;
    start_run(8'd3);
    wait_done(3000);
    check("t1_busy_at_done", busy_o, 1);
    check("t1_sum", sum_o, 320);
    check("t1_err", err_timeout_o, 0);
    check("t1_min", hw_min_o, MM ? 20 : 0);
    check("t1_max", hw_max_o, MM ? 20 : 0);
    check("t1_gap", t_c - t_l, 4);
    check("t1_samples", smp, 16);
    @(negedge clk);
    check("t1_busy_after", busy_o, 0);
    check("t1_done_cnt", done_cnt, 1);

    // ramp 0..15, cfg_delay 0
    for (int i = 0; i < 16; i++) hw_tab[i] = 7'(i);
    start_run(8'd0);
    wait_done(3000);
    check("t2_sum", sum_o, 120);
    check("t2_min", hw_min_o, 0);
    check("t2_max", hw_max_o, MM ? 15 : 0);
    check("t2_gap0", t_c - t_l, 1);
    for (int i = 0; i < 16; i++) hw_tab[i] = 7'd5;
    start_run(8'd255);
    wait_done(6000);
    check("t2_gap255", t_c - t_l, 256);
    check("t2_sum255", sum_o, 80);

    // no response: timeout in COLLECT
    resp_on = 1'b0;
    start_run(8'd2);
    wait_done(2000);
    check("t3_err", err_timeout_o, 1);
    check("t3_to_gap", t_d - t_c, 256);
    check("t3_launch", clk_launch_o, 0);
    check("t3_capture", clk_capture_o, 0);
    check("t3_val_in", val_in_o, 0);
    check("t3_sum", sum_o, 0);
    resp_on = 1'b1;

    // val_out stuck high after sample 3: timeout in RECOVER
    for (int i = 0; i < 16; i++) hw_tab[i] = 7'(10 + i);
    stuck_n = 3;
    start_run(8'd1);
    wait_done(2000);
    check("t4_err", err_timeout_o, 1);
    check("t4_sum", sum_o, 33);
    check("t4_min", hw_min_o, MM ? 10 : 0);
    check("t4_max", hw_max_o, MM ? 12 : 0);
    check("t4_samples", smp, 3);
    stuck_n = 0;
    repeat (2) @(negedge clk);

    // start while busy is ignored
    for (int i = 0; i < 16; i++) hw_tab[i] = 7'd20;
    done_cnt = 0;
    start_run(8'd3);
    repeat (30) @(negedge clk);
    check("t5_err_cleared", err_timeout_o, 0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(3000);
    check("t5_sum", sum_o, 320);
    check("t5_samples", smp, 16);
    @(negedge clk);
    check("t5_done_cnt", done_cnt, 1);

    // en dropped during WAIT of the third sample
    done_cnt = 0;
    n_launch = 0;
    start_run(8'd10);
    begin
      int w = 0;
      while (n_launch < 3 && w < 500) begin
        @(negedge clk);
        w++;
      end
    end
    check("t5_launch3", n_launch, 3);
    @(negedge clk);
    en_i = 1'b0;
    @(negedge clk);
    check("t5_en_busy", busy_o, 0);
    check("t5_en_launch", clk_launch_o, 0);
    check("t5_en_val_in", val_in_o, 0);
    check("t5_en_sum", sum_o, 40);
    repeat (5) @(negedge clk);
    check("t5_en_no_done", done_cnt, 0);
    check("t5_en_sum_hold", sum_o, 40);

    // rst during COLLECT of the second sample
    en_i = 1'b1;
    start_run(8'd2);
    begin
      int w = 0;
      while (!(clk_capture_o && sum_o == 20) && w < 200) begin
        @(negedge clk);
        w++;
      end
    end
    check("t6_reached", sum_o, 20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_launch", clk_launch_o, 0);
    check("t6_capture", clk_capture_o, 0);
    check("t6_val_in", val_in_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_done", done_o, 0);
    check("t6_err", err_timeout_o, 0);
    check("t6_sum", sum_o, 0);
    check("t6_min", hw_min_o, MM ? 127 : 0);
    check("t6_max", hw_max_o, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
